// File: rtl/imm_pkg.sv
// ---------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate decode pipeline:
//   - imm_type_e : 3-bit immediate format code presented on out_type
//   - OPC_*      : RV32/RV64 major opcode constants (inst[6:0])
//   - imm_classify : maps an opcode (plus funct3[2] for SYSTEM) to a format
//   - imm_fmt_*    : raw 32-bit immediate assembly for each format
// No ports; imported by imm_decode and imm_decode_pipe.
// ---------------------------------------------------------------------------
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I       = 3'd0,
    IMM_S       = 3'd1,
    IMM_B       = 3'd2,
    IMM_U       = 3'd3,
    IMM_J       = 3'd4,
    IMM_Z       = 3'd5,
    IMM_NONE    = 3'd6,
    IMM_ILLEGAL = 3'd7
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // Opcode to format. The full 7-bit compare also rejects compressed
  // encodings (inst[1:0] != 2'b11), since none of the constants match them.
  // The *W opcodes only exist on RV64, so they are illegal when rv64 is low.
  function automatic imm_type_e imm_classify(input logic [6:0] opcode,
                                             input logic       funct3_msb,
                                             input logic       rv64);
    imm_type_e t;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      OPC_SYSTEM:                     t = funct3_msb ? IMM_Z : IMM_I;
      OPC_OP:                         t = IMM_NONE;
      OPC_OP_IMM_32:                  t = rv64 ? IMM_I : IMM_ILLEGAL;
      OPC_OP_32:                      t = rv64 ? IMM_NONE : IMM_ILLEGAL;
      default:                        t = IMM_ILLEGAL;
    endcase
    return t;
  endfunction

  // Each helper returns a 32-bit value already sign-extended to bit 31, so
  // widening to XLEN afterwards is a single signed cast.
  function automatic logic [31:0] imm_fmt_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_fmt_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_fmt_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_fmt_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_fmt_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // CSR immediate: the rs1 field is an unsigned 5-bit value.
  function automatic logic [31:0] imm_fmt_z(input logic [31:0] inst);
    return {27'b0, inst[19:15]};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate decoder sitting between the two pipeline
// registers of imm_decode_pipe.
// Parameters:
//   XLEN     : width of the produced immediate (32 or 64)
// Ports:
//   instr    : in  [31:0]     full instruction word
//   imm      : out [XLEN-1:0] extended immediate (0 for NONE / ILLEGAL)
//   imm_type : out [2:0]      format code (imm_type_e encoding)
// ---------------------------------------------------------------------------
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type
);

  imm_type_e   fmt;
  logic [31:0] raw;

  // Classify first, then pick the matching bit scatter. Every format helper
  // already yields a value correct at 32 bits, so the XLEN=64 result is just
  // a sign extension of it; Z is zero in bit 31 and therefore stays
  // zero-extended, and NONE/ILLEGAL select zero.
  always_comb begin
    fmt = imm_classify(instr[6:0], instr[14], XLEN == 64);
    raw = '0;
    case (fmt)
      IMM_I:   raw = imm_fmt_i(instr);
      IMM_S:   raw = imm_fmt_s(instr);
      IMM_B:   raw = imm_fmt_b(instr);
      IMM_U:   raw = imm_fmt_u(instr);
      IMM_J:   raw = imm_fmt_j(instr);
      IMM_Z:   raw = imm_fmt_z(instr);
      default: raw = '0;
    endcase
    imm      = XLEN'($signed(raw));
    imm_type = fmt;
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// ---------------------------------------------------------------------------
// imm_decode_pipe
// Two-stage valid/ready pipeline that extracts and extends the immediate of
// an RV32/RV64 instruction. S1 registers the raw instruction and tag, the
// imm_decode block works on S1, and S2 registers the decoded result which
// drives the out_* ports directly.
// Parameters:
//   XLEN        : immediate width, 32 or 64
//   TAG_W       : width of the opaque sideband tag
// Ports:
//   clk         : in   clock, rising edge
//   reset       : in   synchronous active-high reset
//   flush       : in   drop every in-flight entry at the next edge
//   in_valid    : in   in_instr / in_tag are valid
//   in_ready    : out  block accepts this cycle
//   in_instr    : in   [31:0] instruction word
//   in_tag      : in   [TAG_W-1:0] sideband tag
//   out_valid   : out  out_* fields are valid
//   out_ready   : in   consumer accepts this cycle
//   out_imm     : out  [XLEN-1:0] extended immediate
//   out_type    : out  [2:0] immediate format code
//   out_illegal : out  out_type is ILLEGAL
//   out_tag     : out  [TAG_W-1:0] tag of the presented entry
// ---------------------------------------------------------------------------
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Stage 1: raw instruction
  logic             s1_valid;
  logic [31:0]      s1_instr;
  logic [TAG_W-1:0] s1_tag;

  // Stage 2: decoded result
  logic             s2_valid;
  logic [XLEN-1:0]  s2_imm;
  logic [2:0]       s2_type;
  logic [TAG_W-1:0] s2_tag;

  // Decoder outputs for the S1 entry
  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_type;

  // Handshake helpers
  logic s2_free;
  logic s1_adv;
  logic in_fire;

  // A stage can take new data when it is empty or its occupant is leaving
  // in the same cycle. in_ready therefore chains combinationally from
  // out_ready, which keeps full throughput with only two entries of storage.
  // Reset and flush both force in_ready low so nothing is accepted into a
  // pipeline that is being cleared.
  always_comb begin
    s2_free  = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !reset && !flush && (!s1_valid || s1_adv);
    in_fire  = in_valid && in_ready;
  end

  imm_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr    (s1_instr),
    .imm      (dec_imm),
    .imm_type (dec_type)
  );

  // S1 register. Payload only loads on an accepted transfer so a stalled
  // entry keeps its contents. Flush kills the valid bit but leaves the
  // payload alone; it will be overwritten by the next accepted input.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_fire || (s1_valid && !s1_adv);
      if (in_fire) begin
        s1_instr <= in_instr;
        s1_tag   <= in_tag;
      end
    end
  end

  // S2 register. Loading only when S1 advances keeps out_* frozen while the
  // consumer stalls, and holds the last value once the entry drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_imm   <= '0;
      s2_type  <= '0;
      s2_tag   <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_adv || (s2_valid && !out_ready);
      if (s1_adv) begin
        s2_imm  <= dec_imm;
        s2_type <= dec_type;
        s2_tag  <= s1_tag;
      end
    end
  end

  always_comb begin
    out_valid   = s2_valid;
    out_imm     = s2_imm;
    out_type    = s2_type;
    out_illegal = (s2_type == IMM_ILLEGAL);
    out_tag     = s2_tag;
  end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_decode_pipe
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
// compares both against a queue-based reference model of the pipeline and
// an arithmetic model of the immediate formats.
// ---------------------------------------------------------------------------
module tb_imm_decode_pipe;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  logic             in_ready32, out_valid32, out_illegal32;
  logic [31:0]      out_imm32;
  logic [2:0]       out_type32;
  logic [TAG_W-1:0] out_tag32;

  logic             in_ready64, out_valid64, out_illegal64;
  logic [63:0]      out_imm64;
  logic [2:0]       out_type64;
  logic [TAG_W-1:0] out_tag64;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_type(out_type32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  imm_decode_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_type(out_type64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  // Model: every accepted instruction waits in a FIFO; its age counts edges
  // since acceptance. The oldest entry is visible once it has seen two edges.
  typedef struct {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
    int               age;
  } entry_t;

  entry_t sb[$];
  int     checks = 0;
  int     errors = 0;
  logic   prev_reset = 1'b0;

  // Immediate value computed as a signed integer from the field weights.
  function automatic void ref_decode(input logic [31:0] w, input int xlen,
                                     output logic [2:0] t, output logic [63:0] imm);
    longint v;
    longint s;
    s = w[31] ? 1 : 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: t = 3'd0;
      7'h23:               t = 3'd1;
      7'h63:               t = 3'd2;
      7'h37, 7'h17:        t = 3'd3;
      7'h6F:               t = 3'd4;
      7'h73:               t = w[14] ? 3'd5 : 3'd0;
      7'h33:               t = 3'd6;
      7'h1B:               t = (xlen == 64) ? 3'd0 : 3'd7;
      7'h3B:               t = (xlen == 64) ? 3'd6 : 3'd7;
      default:             t = 3'd7;
    endcase
    case (t)
      3'd0: v = longint'(w[31:20]) - s * 4096;
      3'd1: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - s * 4096;
      3'd2: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                + longint'(w[11:8]) * 2 - s * 4096;
      3'd3: v = longint'(w[31:12]) * 4096 - s * 64'sh1_0000_0000;
      3'd4: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                + longint'(w[30:21]) * 2 - s * 1048576;
      3'd5: v = longint'(w[19:15]);
      default: v = 0;
    endcase
    imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the
  // model across the rising edge. Called at posedge+1.
  task automatic apply_stimulus(input logic v, input logic [31:0] ins,
                                input logic [TAG_W-1:0] tg, input logic ordy,
                                input logic fl, input logic rst);
    logic        exp_ready, exp_valid, acc;
    logic [2:0]  t32, t64;
    logic [63:0] i32, i64;
    in_valid = v; in_instr = ins; in_tag = tg;
    out_ready = ordy; flush = fl; reset = rst;
    #2;
    exp_ready = !rst && !fl && (sb.size() < 2 || ordy);
    exp_valid = (sb.size() > 0) && (sb[0].age >= 2);
    check_output("in_ready32", in_ready32, exp_ready);
    check_output("in_ready64", in_ready64, exp_ready);
    check_output("out_valid32", out_valid32, exp_valid);
    check_output("out_valid64", out_valid64, exp_valid);
    if (prev_reset) begin
      check_output("rst_imm32", out_imm32, 0);
      check_output("rst_type32", out_type32, 0);
      check_output("rst_illegal32", out_illegal32, 0);
      check_output("rst_tag32", out_tag32, 0);
      check_output("rst_imm64", out_imm64, 0);
    end
    if (exp_valid) begin
      ref_decode(sb[0].instr, 32, t32, i32);
      ref_decode(sb[0].instr, 64, t64, i64);
      check_output("imm32", out_imm32, i32);
      check_output("type32", out_type32, t32);
      check_output("illegal32", out_illegal32, t32 == 3'd7);
      check_output("tag32", out_tag32, sb[0].tag);
      check_output("imm64", out_imm64, i64);
      check_output("type64", out_type64, t64);
      check_output("illegal64", out_illegal64, t64 == 3'd7);
      check_output("tag64", out_tag64, sb[0].tag);
    end
    acc = v && exp_ready;
    @(posedge clk);
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (exp_valid && ordy) void'(sb.pop_front());
      foreach (sb[i]) sb[i].age++;
      if (acc) sb.push_back('{ins, tg, 1});
    end
    prev_reset = rst;
    #1;
  endtask

  logic [6:0] opc_list [12] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37,
                                7'h17, 7'h6F, 7'h73, 7'h33, 7'h1B, 7'h3B};

  initial begin
    logic [31:0] rnd;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    prev_reset = 1'b1;

    // Directed formats, unstalled
    apply_stimulus(1, 32'hFFF00093, 4'd3, 1, 0, 0);
    apply_stimulus(1, 32'hFE000EE3, 4'd5, 1, 0, 0);
    apply_stimulus(1, 32'h12345037, 4'd6, 1, 0, 0);
    apply_stimulus(1, 32'h300FD073, 4'd7, 1, 0, 0);
    apply_stimulus(1, 32'h0000001B, 4'd8, 1, 0, 0);
    apply_stimulus(1, 32'hFFFFFFFF, 4'd9, 1, 0, 0);
    apply_stimulus(1, 32'h00B50533, 4'd10, 1, 0, 0);
    apply_stimulus(1, 32'h0000003B, 4'd11, 1, 0, 0);
    apply_stimulus(1, 32'h8000006F, 4'd12, 1, 0, 0);
    apply_stimulus(1, 32'hFE112E23, 4'd13, 1, 0, 0);
    repeat (3) apply_stimulus(0, 32'h0, 4'd0, 1, 0, 0);

    // Stall with three back-to-back offers; the third is refused until release
    apply_stimulus(1, 32'h00100093, 4'd1, 0, 0, 0);
    apply_stimulus(1, 32'h00200113, 4'd2, 0, 0, 0);
    apply_stimulus(1, 32'h00300193, 4'd3, 0, 0, 0);
    apply_stimulus(1, 32'h00300193, 4'd3, 0, 0, 0);
    apply_stimulus(1, 32'h00300193, 4'd3, 1, 0, 0);
    repeat (4) apply_stimulus(0, 32'h0, 4'd0, 1, 0, 0);

    // Flush with both stages full, plus an offer during the flush cycle
    apply_stimulus(1, 32'h00400213, 4'd4, 0, 0, 0);
    apply_stimulus(1, 32'h00500293, 4'd5, 0, 0, 0);
    apply_stimulus(1, 32'h00600313, 4'd6, 0, 1, 0);
    repeat (3) apply_stimulus(0, 32'h0, 4'd0, 1, 0, 0);

    // Reset in the middle of a stall
    apply_stimulus(1, 32'hFFF00093, 4'd14, 0, 0, 0);
    apply_stimulus(1, 32'hFE000EE3, 4'd15, 0, 0, 0);
    apply_stimulus(1, 32'h12345037, 4'd1, 0, 1, 1);
    apply_stimulus(0, 32'h0, 4'd0, 1, 0, 0);
    repeat (2) apply_stimulus(0, 32'h0, 4'd0, 1, 0, 0);

    // Randomised traffic with occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      rnd = $urandom;
      if ($urandom_range(0, 99) < 80) rnd[6:0] = opc_list[$urandom_range(0, 11)];
      apply_stimulus($urandom_range(0, 99) < 70, rnd, TAG_W'($urandom),
                     $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3,
                     $urandom_range(0, 99) < 2);
    end
    repeat (4) apply_stimulus(0, 32'h0, 4'd0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
